// File: rtl/wb_pwm_pkg.sv
// Shared definitions for the Wishbone PWM peripheral: register map,
// field positions and the byte-lane merge used by register writes.
package wb_pwm_pkg;

    localparam int WIN_W = 5;

    localparam logic [WIN_W-1:0] OFF_CTRL   = 5'h00;
    localparam logic [WIN_W-1:0] OFF_PRESC  = 5'h04;
    localparam logic [WIN_W-1:0] OFF_PERIOD = 5'h08;
    localparam logic [WIN_W-1:0] OFF_DUTY   = 5'h0C;
    localparam logic [WIN_W-1:0] OFF_STATUS = 5'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_POL    = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_W      = 3;

    localparam int STATUS_PEND    = 0;
    localparam int STATUS_CNT_LSB = 16;

    // Replace only the byte lanes selected by sel, keep the rest of old_val.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/wb_pwm_core.sv
// PWM engine: prescaler, period counter, double-buffered period/duty and
// registered compare output. Emits a one-cycle pulse on each period wrap.
module wb_pwm_core #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_pol,
    input  logic [15:0]      i_presc,
    input  logic [CNT_W-1:0] i_period_stg,
    input  logic [CNT_W-1:0] i_duty_stg,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_pwm,
    output logic             o_wrap
);
    import wb_pwm_pkg::*;

    logic             r_en_d;
    logic [15:0]      r_presc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act_period;
    logic [CNT_W-1:0] r_act_duty;
    logic             r_pwm;

    logic             w_start;
    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] w_duty;
    logic             w_tick;
    logic             w_at_end;

    // The enabling cycle already counts, using the staging values directly.
    assign w_start  = i_en & ~r_en_d;
    assign w_period = w_start ? i_period_stg : r_act_period;
    assign w_duty   = w_start ? i_duty_stg   : r_act_duty;
    // >= keeps the prescaler from running the full 16-bit range if PRESC shrinks mid-count.
    assign w_tick   = (r_presc >= i_presc);
    assign w_at_end = (r_cnt == w_period);
    assign o_wrap   = i_en & w_tick & w_at_end;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en_d       <= 1'b0;
            r_presc      <= '0;
            r_cnt        <= '0;
            r_act_period <= '0;
            r_act_duty   <= '0;
            r_pwm        <= 1'b0;
        end else begin
            r_en_d <= i_en;
            if (!i_en) begin
                r_presc <= '0;
                r_cnt   <= '0;
                r_pwm   <= i_pol;
            end else begin
                r_pwm <= (r_cnt < w_duty) ^ i_pol;
                if (w_start) begin
                    r_act_period <= i_period_stg;
                    r_act_duty   <= i_duty_stg;
                end
                if (w_tick) begin
                    r_presc <= '0;
                    if (w_at_end) begin
                        r_cnt        <= '0;
                        r_act_period <= i_period_stg;
                        r_act_duty   <= i_duty_stg;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_pwm = r_pwm;

endmodule

// File: rtl/wb_pwm_ctrl.sv
// Wishbone slave front end for the PWM peripheral: address decode, two-clock
// ack, register file with byte enables, sticky PEND and the interrupt line.
module wb_pwm_ctrl
    import wb_pwm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
    parameter int          CNT_W     = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        pwm_out,
    output logic        irq_o
);

    logic              r_ack;
    logic [31:0]       r_dat;
    logic [CTRL_W-1:0] r_ctrl;
    logic [15:0]       r_presc;
    logic [CNT_W-1:0]  r_period;
    logic [CNT_W-1:0]  r_duty;
    logic              r_pend;
    logic              r_irq;

    logic              w_hit;
    logic              w_req;
    logic              w_wr;
    logic [WIN_W-1:0]  w_off;
    logic [31:0]       w_rd_word;
    logic [31:0]       w_wr_word;
    logic              w_w1c;
    logic [CTRL_W-1:0] w_ctrl_nxt;
    logic              w_pend_nxt;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_pwm;
    logic              w_wrap;
    logic              w_unused_bits;

    assign w_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:WIN_W] == BASE_ADDR[31:WIN_W]);
    // A request is only taken while ack is low, which forces the idle cycle after each ack.
    assign w_req = w_hit & ~r_ack;
    assign w_wr  = w_req & wbs_we_i;
    assign w_off = wbs_adr_i[WIN_W-1:0];

    always_comb begin
        w_rd_word = '0;
        case (w_off)
            OFF_CTRL:   w_rd_word[CTRL_W-1:0] = r_ctrl;
            OFF_PRESC:  w_rd_word[15:0]       = r_presc;
            OFF_PERIOD: w_rd_word[CNT_W-1:0]  = r_period;
            OFF_DUTY:   w_rd_word[CNT_W-1:0]  = r_duty;
            OFF_STATUS: begin
                w_rd_word[STATUS_PEND]             = r_pend;
                w_rd_word[STATUS_CNT_LSB +: CNT_W] = w_cnt;
            end
            default: w_rd_word = '0;
        endcase
    end

    assign w_wr_word     = byte_merge(w_rd_word, wbs_dat_i, wbs_sel_i);
    assign w_unused_bits = ^w_wr_word;

    assign w_w1c      = w_wr & (w_off == OFF_STATUS) & wbs_sel_i[0] & wbs_dat_i[STATUS_PEND];
    assign w_ctrl_nxt = (w_wr && w_off == OFF_CTRL) ? w_wr_word[CTRL_W-1:0] : r_ctrl;
    // A wrap in the same cycle as a clear leaves PEND set.
    assign w_pend_nxt = w_wrap | (r_pend & ~w_w1c);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_ctrl   <= '0;
            r_presc  <= '0;
            r_period <= '0;
            r_duty   <= '0;
            r_pend   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ack  <= w_req;
            r_dat  <= (w_req && !wbs_we_i) ? w_rd_word : '0;
            r_ctrl <= w_ctrl_nxt;
            if (w_wr && w_off == OFF_PRESC) begin
                r_presc <= w_wr_word[15:0];
            end
            if (w_wr && w_off == OFF_PERIOD) begin
                r_period <= w_wr_word[CNT_W-1:0];
            end
            if (w_wr && w_off == OFF_DUTY) begin
                r_duty <= w_wr_word[CNT_W-1:0];
            end
            r_pend <= w_pend_nxt;
            r_irq  <= w_pend_nxt & w_ctrl_nxt[CTRL_IRQ_EN];
        end
    end

    wb_pwm_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .i_clk        (wb_clk_i),
        .i_rst        (wb_rst_i),
        .i_en         (r_ctrl[CTRL_EN]),
        .i_pol        (r_ctrl[CTRL_POL]),
        .i_presc      (r_presc),
        .i_period_stg (r_period),
        .i_duty_stg   (r_duty),
        .o_cnt        (w_cnt),
        .o_pwm        (w_pwm),
        .o_wrap       (w_wrap)
    );

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign pwm_out   = w_pwm;
    assign irq_o     = r_irq;

endmodule

// File: tb/tb_wb_pwm_ctrl.sv
// Self-checking bench for wb_pwm_ctrl: directed register/bus cases plus
// randomized PWM phases checked against a cycle-arithmetic waveform model.
module tb_wb_pwm_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0100;
    localparam int          BIG  = 1 << 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic        pwm, irq;

    wb_pwm_ctrl dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_w),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_r),
        .pwm_out   (pwm),
        .irq_o     (irq)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h edge=%0d", tag, got, exp, edge_cnt);
        end
    endtask

    // ---------------- reference model ----------------
    // One enabled phase: enable committed at edge ph_e, fixed prescaler/period,
    // duty ph_d0 until a staging write at edge ph_wd switches later periods to ph_d1.
    int ph_e = 0, ph_p = 0, ph_n = 0, ph_d0 = 0, ph_d1 = 0, ph_wd = BIG;
    bit ph_pol = 1'b0, ph_irq_en = 1'b0, mon_on = 1'b0;
    int clr_edge = -1;

    function automatic int len_l();
        return (ph_n + 1) * (ph_p + 1);
    endfunction

    // Counter value during the k-th clock after the enable edge.
    function automatic int model_cnt(input int k);
        if (k < 0) return 0;
        return (k % len_l()) / (ph_p + 1);
    endfunction

    function automatic bit model_pwm(input int e);
        int k, j, duty;
        k = e - ph_e - 1;
        if (k < 0) return ph_pol;
        j = k / len_l();
        duty = (j > 0 && j * len_l() - 1 >= ph_wd - ph_e) ? ph_d1 : ph_d0;
        return (model_cnt(k) < duty) ^ ph_pol;
    endfunction

    // PEND after edge e: set at every wrap edge ph_e + m*L, cleared by a later W1C.
    function automatic bit model_pend(input int e);
        int last_set;
        if (e - ph_e < len_l()) return 1'b0;
        last_set = ph_e + ((e - ph_e) / len_l()) * len_l();
        return !(clr_edge > last_set && clr_edge <= e);
    endfunction

    always @(posedge clk) begin
        #1;
        if (mon_on && edge_cnt > ph_e) begin
            check("pwm", 32'(pwm), 32'(model_pwm(edge_cnt)));
            check("irq", 32'(irq), 32'(ph_irq_en & model_pend(edge_cnt)));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] wdata,
                           input logic [3:0] sel_v, input bit arm,
                           output logic [31:0] rdata, output bit acked, output int ack_edge);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = wr; adr = a; dat_w = wdata; sel = sel_v;
        if (wr && a == BASE + 32'h10 && sel_v[0] && wdata[0]) clr_edge = edge_cnt + 1;
        if (arm) begin
            ph_e   = edge_cnt + 1;
            ph_wd  = BIG;
            mon_on = 1'b1;
        end
        acked = 1'b0; rdata = '0; ack_edge = -1;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked    = 1'b1;
                rdata    = dat_r;
                ack_edge = edge_cnt;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        if (acked) check("ack_one_cycle", 32'(ack), 32'd0);
    endtask

    task automatic wr_full(input logic [4:0] off, input logic [31:0] d, input logic [3:0] s,
                           input bit arm, output int ae);
        logic [31:0] rd_d; bit acked;
        wb_xfer(1'b1, BASE + {27'b0, off}, d, s, arm, rd_d, acked, ae);
        check("wr_ack", 32'(acked), 32'd1);
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d);
        int ae;
        wr_full(off, d, 4'hF, 1'b0, ae);
    endtask

    task automatic rd(input string tag, input logic [4:0] off, input logic [31:0] exp);
        logic [31:0] rdata; bit acked; int ae;
        exp_q.push_back(exp);
        wb_xfer(1'b0, BASE + {27'b0, off}, '0, 4'hF, 1'b0, rdata, acked, ae);
        check({tag, "_ack"}, 32'(acked), 32'd1);
        check(tag, rdata, exp_q.pop_front());
    endtask

    task automatic rd_status();
        logic [31:0] rdata; bit acked; int ae;
        wb_xfer(1'b0, BASE + 32'h10, '0, 4'hF, 1'b0, rdata, acked, ae);
        check("status_ack", 32'(acked), 32'd1);
        if (acked) begin
            exp_q.push_back((32'(model_cnt(ae - 1 - ph_e)) << 16) | 32'(model_pend(ae - 1)));
            check("status", rdata, exp_q.pop_front());
        end
    endtask

    task automatic wait_neg(input int target);
        while (edge_cnt < target) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_phase(input int p, input int n, input int d, input bit pol, input bit ie);
        int ae;
        wr(5'h00, {29'b0, 1'b0, pol, 1'b0});
        wr(5'h10, 32'h1);
        wr(5'h04, 32'(p));
        wr(5'h08, 32'(n));
        wr(5'h0C, 32'(d));
        ph_p = p; ph_n = n; ph_d0 = d; ph_d1 = d; ph_pol = pol; ph_irq_en = ie;
        wr_full(5'h00, {29'b0, ie, pol, 1'b1}, 4'hF, 1'b1, ae);
    endtask

    task automatic end_phase();
        int ae;
        @(negedge clk);
        mon_on = 1'b0;
        wr_full(5'h00, {29'b0, 1'b0, ph_pol, 1'b0}, 4'hF, 1'b0, ae);
        check("idle_level", 32'(pwm), 32'(ph_pol));
    endtask

    task automatic duty_change(input int d1);
        int ae;
        ph_d1 = d1;
        wr_full(5'h0C, 32'(d1), 4'hF, 1'b0, ae);
        ph_wd = ae;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rdata;
        bit          acked;
        int          ae, x;
        bit          duty_done;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat_w = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_r, 32'd0);
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        for (int i = 0; i < 6; i++) rd("rst_reg", 5'(4 * i), 32'd0);

        // Held strobe: ack pulses every other cycle
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("held_ack", 32'(ack), 32'((i % 2) == 0));
        end
        cyc = 1'b0; stb = 1'b0;
        idle(2);

        // Byte lanes and unmapped / out-of-window accesses
        wr(5'h08, 32'h0000_0034);
        wr_full(5'h08, 32'h0000_AB00, 4'b0010, 1'b0, ae);
        rd("period_byte", 5'h08, 32'h0000_AB34);
        wr_full(5'h04, 32'hFFFF_0000, 4'b1100, 1'b0, ae);
        rd("presc_upper", 5'h04, 32'h0);
        wr(5'h14, 32'hFFFF_FFFF);
        rd("unmapped", 5'h14, 32'h0);
        wb_xfer(1'b1, BASE + 32'h40, 32'h5, 4'hF, 1'b0, rdata, acked, ae);
        check("oow_no_ack", 32'(acked), 32'd0);
        wr(5'h0C, 32'h0001_2345);
        rd("duty_rw", 5'h0C, 32'h0000_2345);

        // 30% duty, PRESC=0, counter visible in STATUS
        start_phase(0, 9, 3, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            idle($urandom_range(0, 3));
            rd_status();
        end
        end_phase();

        // DUTY>PERIOD then DUTY=0 mid-period
        start_phase(4, 3, 4, 1'b0, 1'b0);
        idle(28);
        duty_change(0);
        idle(50);
        end_phase();

        // Inverted polarity
        wr(5'h00, 32'h2);
        idle(1);
        check("pol_idle", 32'(pwm), 32'd1);
        start_phase(0, 7, 2, 1'b1, 1'b0);
        idle(30);
        end_phase();

        // Interrupt: W1C on a wrap edge keeps PEND, off-wrap clears it
        start_phase(0, 4, 2, 1'b0, 1'b1);
        x = ph_e + 3 * len_l();
        wait_neg(x - 2);
        wr(5'h10, 32'h1);
        check("set_wins", 32'(irq), 32'd1);
        x = ph_e + 4 * len_l() + 2;
        wait_neg(x - 2);
        wr(5'h10, 32'h1);
        check("w1c_clear", 32'(irq), 32'd0);
        rd_status();
        idle(12);
        end_phase();

        // Randomized phases
        for (int it = 0; it < 10; it++) begin
            int p, n;
            p = $urandom_range(0, 3);
            n = $urandom_range(0, 9);
            start_phase(p, n, $urandom_range(0, n + 2), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
            duty_done = 1'b0;
            for (int op = 0; op < 12; op++) begin
                case ($urandom_range(0, 3))
                    0: idle($urandom_range(1, 8));
                    1: rd_status();
                    2: if (!duty_done) begin
                           duty_change($urandom_range(0, n + 2));
                           duty_done = 1'b1;
                       end
                    default: wr(5'h10, 32'h1);
                endcase
            end
            idle(2 * len_l());
            end_phase();
        end

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
